// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
// One quotient bit per cycle over WIDTH steps; divide-by-zero, signed overflow and non-divide ops resolve at accept.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quot_q, dvsr_q, result_q;
  logic             is_rem_q, neg_quot_q, neg_rem_q;

  logic             accept, req_signed, req_rem, a_neg, b_neg;
  logic             not_div, div_zero, overflow, special;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;
  logic [WIDTH:0]   rem_sh;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_nx, quot_nx, quot_fix, rem_fix;

  // Request decode; funct3[0] clear selects the signed variants.
  always_comb begin
    accept      = req_valid && req_ready;
    req_signed  = ~funct3[0];
    req_rem     = funct3[1];
    a_neg       = req_signed & a[WIDTH-1];
    b_neg       = req_signed & b[WIDTH-1];
    a_mag       = a_neg ? -a : a;
    b_mag       = b_neg ? -b : b;
    not_div     = ~funct3[2];
    div_zero    = (b == '0);
    overflow    = req_signed && (a == MIN_NEG) && (b == '1);
    special     = not_div || div_zero || overflow;
    special_res = '0;
    if (!not_div) begin
      if (div_zero) special_res = req_rem ? a : '1;
      else          special_res = req_rem ? '0 : MIN_NEG;
    end
  end

  // Restoring step: remainder never reaches 2*divisor, so the low WIDTH bits of the difference are exact.
  always_comb begin
    rem_sh    = {rem_q, quot_q[WIDTH-1]};
    no_borrow = (rem_sh >= {1'b0, dvsr_q});
    rem_nx    = no_borrow ? (rem_sh[WIDTH-1:0] - dvsr_q) : rem_sh[WIDTH-1:0];
    quot_nx   = {quot_q[WIDTH-2:0], no_borrow};
    quot_fix  = neg_quot_q ? -quot_nx : quot_nx;
    rem_fix   = neg_rem_q ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : CALC;
      CALC:    if (cnt_q == LAST_STEP) state_d = DONE;
      DONE:    if (resp_valid && resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && !flush;
    resp_valid = (state_q == DONE);
    busy       = (state_q != IDLE);
    result     = result_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= a_mag;
            dvsr_q     <= b_mag;
            is_rem_q   <= req_rem;
            neg_quot_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            if (special) result_q <= special_res;
          end
        end
        CALC: begin
          rem_q  <= rem_nx;
          quot_q <= quot_nx;
          if (cnt_q == LAST_STEP) begin
            cnt_q    <= '0;
            result_q <= is_rem_q ? rem_fix : quot_fix;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq against an arithmetic reference model
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
  logic [2:0]  funct3;
  logic [31:0] a, b, result;

  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .a(a), .b(b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    if (!f[2]) return 32'h0;
    if (y == 32'h0) return f[1] ? x : 32'hFFFF_FFFF;
    if (!f[0]) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
      return f[1] ? sx % sy : sx / sy;
    end
    return f[1] ? x % y : x / y;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (!f[2] || y == 32'h0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Monitor: latency on the rising edge of resp_valid, result every valid cycle, pop on handshake.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {31'h0, resp_valid}, 32'h0);
      end else begin
        if (!prev_v) chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
        chk("result", result, exp_q[0].res);
        if (resp_ready && !flush) void'(exp_q.pop_front());
      end
    end
    prev_v = resp_valid;
  end

  // Called at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    bit   done = 0;
    req_valid = 1'b1;
    funct3 = f;
    a = x;
    b = y;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (req_ready) begin
        e.res = ref_res(f, x, y);
        e.lat = ref_lat(f, x, y);
        e.acc = cyc;
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    funct3 = 3'($urandom);
    a = $urandom;
    b = $urandom;
    if (!done) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_resp();
    bit done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      chk("resp_timeout", 32'h0, 32'h1);
      exp_q.delete();
    end
  endtask

  task automatic wait_valid();
    bit done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (resp_valid) done = 1;
    end
    if (!done) chk("valid_timeout", 32'h0, 32'h1);
  endtask

  logic [2:0]  dir_f[10] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] dir_a[10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'hFFFF_FFFF,
                             32'd5, 32'd42, 32'd42, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dir_b[10] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd1,
                             32'd9, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    logic [2:0]  f;
    logic [31:0] x, y;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    funct3 = 3'd0; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_result", result, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(dir_f[i], dir_a[i], dir_b[i]);
      wait_resp();
    end

    for (int i = 0; i < 30; i++) begin
      f = 3'(4 + $urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 6))
        0: y = 32'h0;
        1: y = $urandom_range(1, 15);
        2: y = 32'hFFFF_FFFF;
        3: begin x = 32'h8000_0000; y = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom; end
        4: begin f = 3'($urandom_range(0, 3)); y = $urandom | 32'h1; end
        default: y = $urandom;
      endcase
      issue(f, x, y);
      wait_resp();
    end

    // Backpressure: result held, new request ignored, then accepted the cycle after handshake.
    resp_ready = 1'b0;
    issue(3'd5, 32'd100, 32'd7);
    wait_valid();
    @(posedge clk); #1;
    req_valid = 1'b1; funct3 = 3'd5; a = 32'd9; b = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
      chk("bp_resp_valid", {31'h0, resp_valid}, 32'h1);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_req_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_req_ready", {31'h0, req_ready}, 32'h1);
    exp_q.push_back('{res: 32'd3, lat: 33, acc: cyc});
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp();

    // Flush during CALC cycle 12.
    issue(3'd4, 32'd1000, 32'd5);
    repeat (11) begin @(posedge clk); #1; end
    flush = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("flush_req_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'h0, busy}, 32'h0);
    chk("flush_req_ready_after", {31'h0, req_ready}, 32'h1);
    repeat (40) @(posedge clk);
    #1;
    issue(3'd5, 32'd9, 32'd3);
    wait_resp();

    // Reset while holding a response in DONE.
    resp_ready = 1'b0;
    issue(3'd4, 32'd42, 32'd0);
    wait_valid();
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("rst_done_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_done_result", result, 32'h0);
    chk("rst_done_req_ready", {31'h0, req_ready}, 32'h1);

    // Flush and request in the same IDLE cycle.
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; funct3 = 3'd4; a = 32'd50; b = 32'd5;
    @(negedge clk);
    chk("flush_idle_req_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", {31'h0, busy}, 32'h0);
    chk("flush_idle_resp_valid", {31'h0, resp_valid}, 32'h0);
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
